// File: rtl/draw_bg_level_if.sv
// VGA timing/pixel bundle shared by the draw chain stages.
// Ports: hcount/vcount pixel coordinates, hsync/vsync, hblnk/vblnk, rgb[11:0].
// master drives every field, slave consumes every field.
interface draw_bg_level_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_bg_level.sv
// Per-level banded background with a frame-paced top-to-bottom wipe on level change.
// Latency: 2 cycles vga_in -> vga_out for every field; no backpressure (pixel stream, one pixel per clk).
// Ports: clk, rst (sync, active-high), level_sel/level_valid request, busy/cur_level status,
//   vga_in (slave, rgb unused), vga_out (master, timing delayed 2 cycles plus rgb).
// Optional macro DRAW_BG_LEVEL_BORDER_EN: adds a 1-pixel coloured frame around the active area.
module draw_bg_level #(
  parameter  int HOR_PIX   = 800,   // active pixels per line (800x600 timing)
  parameter  int VER_PIX   = 600,   // active lines per frame
  parameter  int N_LEVELS  = 4,
  parameter  int BAND_H    = 32,
  parameter  int WIPE_STEP = 16,
  localparam int LW        = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] level_sel,
  input  logic          level_valid,
  output logic          busy,
  output logic [LW-1:0] cur_level,
  draw_bg_level_if.slave  vga_in,
  draw_bg_level_if.master vga_out
);

  localparam int BAND_SH = $clog2(BAND_H);
  // One extra bit so wipe_line + WIPE_STEP never wraps.
  localparam int WL_W    = $clog2(VER_PIX) + 1;
  // Common compare width for vcount (11 bits) against wipe_line (+1).
  localparam int CW      = ((WL_W > 11) ? WL_W : 11) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WIPE = 1'b1;

  logic [0:0]      state;
  logic [LW-1:0]   nxt_level;
  logic [WL_W-1:0] wipe_line;
  logic [WL_W-1:0] wipe_sum;

  // Stage 1 registers
  logic [10:0]   hc1, vc1;
  logic          hs1, vs1, hb1, vb1;
  logic          blank1, odd1, ovr_vld1;
  logic [LW-1:0] lvl1;
  logic [11:0]   ovr_col1;

  // Stage 2 registers (drive vga_out)
  logic [10:0] hc2, vc2;
  logic        hs2, vs2, hb2, vb2;
  logic [11:0] rgb2;

  logic frame_start, accept;

  function automatic logic [11:0] pal(input logic [LW-1:0] l, input logic odd);
    logic [11:0] a;
    a = 12'h468 + 12'(l) * 12'h123;
    return odd ? (a ^ 12'h111) : a;
  endfunction

  assign frame_start = vb1 & ~vb2;
  assign accept      = (state == ST_IDLE) && level_valid &&
                       (32'(level_sel) < N_LEVELS) && (level_sel != cur_level);
  assign wipe_sum    = wipe_line + WL_W'(WIPE_STEP);
  assign busy        = (state == ST_WIPE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      nxt_level <= '0;
      wipe_line <= '0;
      cur_level <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_WIPE;
            nxt_level <= level_sel;
            wipe_line <= '0;
          end
        end
        default: begin
          if (frame_start) begin
            wipe_line <= wipe_sum;
            if (wipe_sum >= WL_W'(VER_PIX)) begin
              state     <= ST_IDLE;
              cur_level <= nxt_level;
            end
          end
        end
      endcase
    end
  end

  // Stage 1 decisions, made against the state seen when the pixel enters.
  logic [CW-1:0] vc_ext, wl_ext;
  logic          in_wipe, sel_nxt, wipe_edge, ovr_vld_c;
  logic [11:0]   ovr_col_c;

  always_comb begin
    vc_ext    = CW'(vga_in.vcount);
    wl_ext    = CW'(wipe_line);
    in_wipe   = (state == ST_WIPE);
    sel_nxt   = in_wipe && (vc_ext < wl_ext);
    wipe_edge = in_wipe && (wipe_line < WL_W'(VER_PIX)) &&
                ((vc_ext == wl_ext) || (vc_ext == wl_ext + CW'(1)));
    ovr_vld_c = 1'b0;
    ovr_col_c = 12'h000;
`ifdef DRAW_BG_LEVEL_BORDER_EN
    if (vga_in.vcount == 11'd0) begin
      ovr_vld_c = 1'b1; ovr_col_c = 12'hFF0;
    end else if (vga_in.vcount == 11'(VER_PIX - 1)) begin
      ovr_vld_c = 1'b1; ovr_col_c = 12'hF00;
    end else if (vga_in.hcount == 11'd0) begin
      ovr_vld_c = 1'b1; ovr_col_c = 12'h0F0;
    end else if (vga_in.hcount == 11'(HOR_PIX - 1)) begin
      ovr_vld_c = 1'b1; ovr_col_c = 12'h00F;
    end else if (wipe_edge) begin
      ovr_vld_c = 1'b1; ovr_col_c = 12'hFFF;
    end
`else
    if (wipe_edge) begin
      ovr_vld_c = 1'b1; ovr_col_c = 12'hFFF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc1 <= '0; vc1 <= '0; hs1 <= 1'b0; vs1 <= 1'b0; hb1 <= 1'b0; vb1 <= 1'b0;
      // Blank is reset high so the first pixel out of reset carries rgb 000.
      blank1   <= 1'b1;
      odd1     <= 1'b0;
      lvl1     <= '0;
      ovr_vld1 <= 1'b0;
      ovr_col1 <= 12'h000;
    end else begin
      hc1      <= vga_in.hcount;
      vc1      <= vga_in.vcount;
      hs1      <= vga_in.hsync;
      vs1      <= vga_in.vsync;
      hb1      <= vga_in.hblnk;
      vb1      <= vga_in.vblnk;
      blank1   <= vga_in.hblnk | vga_in.vblnk;
      odd1     <= vga_in.vcount[BAND_SH];
      lvl1     <= sel_nxt ? nxt_level : cur_level;
      ovr_vld1 <= ovr_vld_c;
      ovr_col1 <= ovr_col_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc2 <= '0; vc2 <= '0; hs2 <= 1'b0; vs2 <= 1'b0; hb2 <= 1'b0; vb2 <= 1'b0;
      rgb2 <= 12'h000;
    end else begin
      hc2 <= hc1; vc2 <= vc1; hs2 <= hs1; vs2 <= vs1; hb2 <= hb1; vb2 <= vb1;
      if (blank1)        rgb2 <= 12'h000;
      else if (ovr_vld1) rgb2 <= ovr_col1;
      else               rgb2 <= pal(lvl1, odd1);
    end
  end

  assign vga_out.hcount = hc2;
  assign vga_out.vcount = vc2;
  assign vga_out.hsync  = hs2;
  assign vga_out.vsync  = vs2;
  assign vga_out.hblnk  = hb2;
  assign vga_out.vblnk  = vb2;
  assign vga_out.rgb    = rgb2;

endmodule

// File: tb/tb_draw_bg_level.sv
// Self-checking bench for draw_bg_level on a reduced 16x30 raster.
module tb_draw_bg_level;

  localparam int HP = 16, VP = 30, NL = 3, BH = 4, WS = 4;
  localparam int H_TOT = 22, V_TOT = 34, FR = H_TOT * V_TOT;
  localparam int WIPE_FRAMES = (VP + WS - 1) / WS;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] level_sel;
  logic       level_valid;
  logic       busy;
  logic [1:0] cur_level;

  draw_bg_level_if vin ();
  draw_bg_level_if vout ();

  draw_bg_level #(.HOR_PIX(HP), .VER_PIX(VP), .N_LEVELS(NL), .BAND_H(BH), .WIPE_STEP(WS)) dut (
    .clk(clk), .rst(rst), .level_sel(level_sel), .level_valid(level_valid),
    .busy(busy), .cur_level(cur_level), .vga_in(vin.slave), .vga_out(vout.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state (spec-level view)
  bit m_busy = 0;
  int m_cur = 0, m_nxt = 0, m_wl = 0;
  bit m_vb1 = 0, m_vb2 = 0;
  int wipe_fs = 0;

  typedef struct {
    logic [37:0] v;
    int ph;
    int hc;
    int vc;
  } pe_t;
  pe_t p1, p2, pz;

  int gh = 0, gv = 0;
  bit busy_prev = 0;

  function automatic logic [11:0] model_rgb(int hc, int vc);
    int lvl, a;
    if (hc >= HP || vc >= VP) return 12'h000;
`ifdef DRAW_BG_LEVEL_BORDER_EN
    if (vc == 0)      return 12'hFF0;
    if (vc == VP - 1) return 12'hF00;
    if (hc == 0)      return 12'h0F0;
    if (hc == HP - 1) return 12'h00F;
`endif
    if (m_busy && m_wl < VP && (vc == m_wl || vc == m_wl + 1)) return 12'hFFF;
    lvl = (m_busy && vc < m_wl) ? m_nxt : m_cur;
    a = (32'h468 + lvl * 32'h123) % 4096;
    if ((vc / BH) % 2 == 1) a = a ^ 32'h111;
    return 12'(a);
  endfunction

  task automatic drive_raster();
    vin.hcount = 11'(gh);
    vin.vcount = 11'(gv);
    vin.hsync  = (gh >= 17 && gh < 20);
    vin.vsync  = (gv >= 31 && gv < 33);
    vin.hblnk  = (gh >= HP);
    vin.vblnk  = (gv >= VP);
    vin.rgb    = 12'h000;
  endtask

  task automatic directed(input pe_t e);
    logic [11:0] o;
    o = vout.rgb;
    if (e.ph == 1) begin
      if (e.hc == 3 && e.vc == 1)      check_val("band0_top", o, 12'h468);
      if (e.hc == 3 && e.vc == BH - 1) check_val("band0_last", o, 12'h468);
      if (e.hc == 3 && e.vc == BH)     check_val("band1_first", o, 12'h579);
      if (e.hc == 3 && e.vc == 2*BH)   check_val("band2_wrap", o, 12'h468);
`ifdef DRAW_BG_LEVEL_BORDER_EN
      if (e.hc == 0 && e.vc == 0)       check_val("border_tl", o, 12'hFF0);
      if (e.hc == HP-1 && e.vc == 13)   check_val("border_r", o, 12'h00F);
      if (e.hc == 5 && e.vc == VP-1)    check_val("border_b", o, 12'hF00);
      if (e.hc == 0 && e.vc == VP-1)    check_val("border_bl", o, 12'hF00);
`else
      if (e.hc == 0 && e.vc == 0)       check_val("noborder_tl", o, 12'h468);
      if (e.hc == HP-1 && e.vc == 13)   check_val("noborder_r", o, 12'h579);
      if (e.hc == 5 && e.vc == VP-1)    check_val("noborder_b", o, 12'h579);
`endif
    end else if (e.ph == 2) begin
      if (e.hc == 3 && e.vc == 1) check_val("wipe_new0", o, 12'h6AE);
      if (e.hc == 3 && e.vc == 3) check_val("wipe_new3", o, 12'h6AE);
      if (e.hc == 3 && e.vc == 4) check_val("wipe_edge4", o, 12'hFFF);
      if (e.hc == 3 && e.vc == 5) check_val("wipe_edge5", o, 12'hFFF);
      if (e.hc == 3 && e.vc == 6) check_val("wipe_old6", o, 12'h579);
      if (e.hc == 3 && e.vc == 8) check_val("wipe_old8", o, 12'h468);
    end
  endtask

  // One clock: update model for the coming edge, clock, check outputs, advance raster.
  task automatic step();
    pe_t ne;
    bit fs, r_edge;
    r_edge = rst;
    if (rst) begin
      m_busy = 0; m_cur = 0; m_nxt = 0; m_wl = 0; m_vb1 = 0; m_vb2 = 0;
      p1 = pz; p2 = pz;
    end else begin
      fs = m_vb1 && !m_vb2;
      ne.v  = {11'(gh), 11'(gv), vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, model_rgb(gh, gv)};
      ne.hc = gh;
      ne.vc = gv;
      ne.ph = (!m_busy && m_cur == 0) ? 1 : (m_busy && m_nxt == 2 && m_wl == WS) ? 2 : 0;
      if (!m_busy) begin
        if (level_valid && int'(level_sel) < NL && int'(level_sel) != m_cur) begin
          m_busy = 1; m_nxt = int'(level_sel); m_wl = 0; wipe_fs = 0;
        end
      end else if (fs) begin
        m_wl += WS;
        wipe_fs++;
        if (m_wl >= VP) begin
          m_cur = m_nxt; m_busy = 0;
        end
      end
      m_vb2 = m_vb1;
      m_vb1 = vin.vblnk;
      p2 = p1;
      p1 = ne;
    end
    @(posedge clk);
    #1;
    check_val("vga_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                          vout.hblnk, vout.vblnk, vout.rgb}, p2.v);
    check_val("busy", busy, m_busy);
    check_val("cur_level", cur_level, m_cur);
    directed(p2);
    if (busy_prev && !busy && !r_edge) check_val("wipe_frames", wipe_fs, WIPE_FRAMES);
    busy_prev = busy;
    gh++;
    if (gh == H_TOT) begin
      gh = 0;
      gv = (gv == V_TOT - 1) ? 0 : gv + 1;
    end
    drive_raster();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_line(input int line);
    for (int i = 0; i < FR && !(gv == line && gh == 0); i++) step();
  endtask

  task automatic request(input int sel);
    level_sel = 2'(sel);
    level_valid = 1'b1;
    step();
    level_valid = 1'b0;
  endtask

  initial begin
    pz.v = '0; pz.ph = 0; pz.hc = 0; pz.vc = 0;
    p1 = pz; p2 = pz;
    rst = 1'b1; level_sel = 2'd0; level_valid = 1'b0;
    drive_raster();
    run_cycles(3);
    check_val("rst_rgb", vout.rgb, 12'h000);
    check_val("rst_busy", busy, 1'b0);
    rst = 1'b0;
    run_cycles(FR + 5);

    // Wipe to level 2 with ignored requests sprinkled in.
    run_to_line(10);
    request(2);
    check_val("busy_rise", busy, 1'b1);
    for (int i = 0; i < 12 * FR && m_busy; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        level_sel = 2'($urandom_range(0, 3));
        level_valid = 1'b1;
      end else level_valid = 1'b0;
      step();
    end
    level_valid = 1'b0;
    check_val("wipe_done_busy", busy, 1'b0);
    check_val("wipe_done_level", cur_level, 2'd2);

    // Requests that must be ignored in IDLE.
    request(2);
    check_val("ign_same", busy, 1'b0);
    request(3);
    check_val("ign_range", busy, 1'b0);
    run_cycles(FR);

    // Reset part-way through a wipe.
    request(1);
    run_cycles(3 * FR);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_level", cur_level, 2'd0);
    run_cycles(2 * FR);

    // Randomised requests.
    for (int i = 0; i < 10 * FR; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        level_sel = 2'($urandom_range(0, 3));
        level_valid = 1'b1;
      end else level_valid = 1'b0;
      step();
    end
    level_valid = 1'b0;
    run_cycles(12 * FR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
